// File: rtl/or_result_packer_if.sv
// Bundle of the packer's bit-input, flush, word-output and counter signals.
// The master side is the stage driving results and consuming words; the slave side is the packer.
interface or_result_packer_if #(
    parameter int WIDTH = 8
);
    logic             in_data;
    logic             in_rdy;
    logic             in_en;
    logic             flush_en;
    logic             flush_rdy;
    logic [WIDTH-1:0] out_data;
    logic             out_rdy;
    logic             out_en;
    logic [15:0]      word_cnt;

    modport master (
        output in_data, in_rdy, flush_en, out_en,
        input  in_en, flush_rdy, out_data, out_rdy, word_cnt
    );

    modport slave (
        input  in_data, in_rdy, flush_en, out_en,
        output in_en, flush_rdy, out_data, out_rdy, word_cnt
    );
endinterface

// File: rtl/or_result_packer.sv
// Packs 1-bit OR results LSB-first into WIDTH-bit words, queues them in a DEPTH-entry FIFO,
// supports zero-padded flush of a partial word and counts dequeued words.
module or_result_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    or_result_packer_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
    localparam logic [FW-1:0] FILL_LIMIT = FW'(DEPTH);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [FW-1:0]    fill_q;
    logic [15:0]      word_cnt_q;

    logic             last_bit;
    logic             room;
    logic             flush_go;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_word;

    // Room uses the start-of-cycle fill, so a dequeue never frees space in the same cycle.
    assign last_bit = (cnt_q == LAST_IDX);
    assign room     = (fill_q < FILL_LIMIT);

    assign bus.in_en     = rst_n & bus.in_rdy & ~bus.flush_en & (~last_bit | room);
    assign bus.flush_rdy = (cnt_q != '0) & room;

    assign flush_go  = bus.flush_en & bus.flush_rdy;
    assign push      = flush_go | (bus.in_en & last_bit);
    assign push_word = flush_go ? acc_q : {bus.in_data, acc_q[WIDTH-2:0]};
    assign pop       = bus.out_en & bus.out_rdy;

    assign bus.out_rdy  = (fill_q != '0);
    assign bus.out_data = bus.out_rdy ? mem[head_q] : '0;
    assign bus.word_cnt = word_cnt_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (flush_go) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (bus.in_en) begin
            if (last_bit) begin
                cnt_d = '0;
                acc_d = '0;
            end else begin
                acc_d[cnt_q] = bus.in_data;
                cnt_d        = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q     <= head_q + PW'(1);
                word_cnt_q <= word_cnt_q + 16'd1;
            end
            // Push and pop together leave fill unchanged; push at full is gated by room.
            case ({push, pop})
                2'b10:   fill_q <= fill_q + FW'(1);
                2'b01:   fill_q <= fill_q - FW'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; stale entries are never observable because
    // out_data is gated by out_rdy, and leaving it unreset lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= push_word;
        end
    end
endmodule
